// File: rtl/cu_seq.sv
// Sequenced calculator control unit: registered one-cycle decode strobes behind a
// valid/ready handshake, with a start/wait/writeback FSM for FACT. Optional WAIT watchdog: CU_TIMEOUT_EN.
module cu_seq #(
    parameter int OPW         = 6,
    parameter int NREG        = 2,
    parameter int RAW         = $clog2(NREG + 2),
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            INSTR_VALID,
    output logic            INSTR_READY,
    input  logic [OPW-1:0]  OPCODE,
    input  logic [RAW-1:0]  REG_ADDR,
    input  logic [3:0]      FLAGS,
    input  logic            MC_DONE,
    output logic            ALU,
    output logic            SEL_FLAG,
    output logic            BRA,
    output logic            COND_BRA,
    output logic [3:0]      BR_COND,
    output logic            LOAD,
    output logic            STORE,
    output logic            COPY,
    output logic            PUSH,
    output logic            POP,
    output logic            MOV,
    output logic [NREG-1:0] SEL_REG,
    output logic            SEL_ACC,
    output logic            SEL_PC,
    output logic            MC_START,
    output logic            MC_BUSY,
    output logic            ILLEGAL,
    output logic            TIMEOUT
);

    localparam logic [5:0] OP_BRA    = 6'b000100;
    localparam logic [5:0] OP_CMP    = 6'b010100;
    localparam logic [5:0] OP_INC    = 6'b010110;
    localparam logic [5:0] OP_DEC    = 6'b010111;
    localparam logic [5:0] OP_NOT    = 6'b010011;
    localparam logic [5:0] OP_LOAD   = 6'b011010;
    localparam logic [5:0] OP_STORE  = 6'b011011;
    localparam logic [5:0] OP_MOV    = 6'b011001;
    localparam logic [5:0] OP_COPY_X = 6'b011100;
    localparam logic [5:0] OP_COPY_Y = 6'b011101;
    localparam logic [5:0] OP_PUSH   = 6'b011110;
    localparam logic [5:0] OP_POP    = 6'b011111;
    localparam logic [5:0] OP_FACT   = 6'b011000;

    localparam logic [RAW-1:0] ACC_ADDR = RAW'(NREG);
    localparam logic [RAW-1:0] PC_ADDR  = RAW'(NREG + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WB
    } state_t;

    typedef struct packed {
        logic            ready;
        logic            alu;
        logic            sel_flag;
        logic            bra;
        logic            cond_bra;
        logic [3:0]      br_cond;
        logic            load;
        logic            store;
        logic            copy;
        logic            push;
        logic            pop;
        logic            mov;
        logic [NREG-1:0] sel_reg;
        logic            sel_acc;
        logic            sel_pc;
        logic            mc_start;
        logic            mc_busy;
        logic            illegal;
        logic            timeout;
    } ctl_t;

    state_t          state_reg, state_next;
    ctl_t            ctl_reg, ctl_next;
    logic [RAW-1:0]  wb_addr_reg, wb_addr_next;
    logic [NREG-1:0] addr_onehot, wb_onehot;
    logic [3:0]      cond_onehot;
    logic [5:0]      op6;
    logic            upper_nz;
    logic            accept;
    logic            reg_ok;
    logic            stk_ok;

    assign op6    = OPCODE[5:0];
    assign accept = INSTR_VALID && ctl_reg.ready;
    assign reg_ok = (REG_ADDR < ACC_ADDR);
    assign stk_ok = (REG_ADDR <= PC_ADDR);

    generate
        if (OPW > 6) begin : g_upper
            assign upper_nz = |OPCODE[OPW-1:6];
        end else begin : g_no_upper
            assign upper_nz = 1'b0;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_sel
            assign addr_onehot[gi] = (REG_ADDR == RAW'(gi));
            assign wb_onehot[gi]   = (wb_addr_reg == RAW'(gi));
        end
        // Branch opcode low bits index the {O,C,N,Z} flag under test.
        for (gi = 0; gi < 4; gi++) begin : g_cond
            assign cond_onehot[gi] = (op6[1:0] == 2'(gi));
        end
    endgenerate

`ifdef CU_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    logic [CW-1:0] wait_cnt_reg, wait_cnt_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end
`else
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
`endif

    always_comb begin
        ctl_next     = '0;
        state_next   = state_reg;
        wb_addr_next = wb_addr_reg;
`ifdef CU_TIMEOUT_EN
        wait_cnt_next = wait_cnt_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                ctl_next.ready = 1'b1;
                if (accept) begin
                    if (upper_nz) begin
                        ctl_next.illegal = 1'b1;
                    end else begin
                        case (op6)
                            6'b000000, 6'b000001, 6'b000010, 6'b000011: begin
                                ctl_next.cond_bra = 1'b1;
                                ctl_next.br_cond  = cond_onehot;
                                ctl_next.bra      = |(FLAGS & cond_onehot);
                            end
                            OP_BRA: ctl_next.bra = 1'b1;
                            OP_CMP: begin
                                ctl_next.alu      = 1'b1;
                                ctl_next.sel_flag = 1'b1;
                            end
                            OP_INC, OP_DEC, OP_NOT: begin
                                if (reg_ok) begin
                                    ctl_next.alu      = 1'b1;
                                    ctl_next.sel_flag = 1'b1;
                                    ctl_next.sel_reg  = addr_onehot;
                                end else begin
                                    ctl_next.illegal = 1'b1;
                                end
                            end
                            OP_LOAD, OP_STORE, OP_MOV: begin
                                if (reg_ok) begin
                                    ctl_next.load    = (op6 == OP_LOAD);
                                    ctl_next.store   = (op6 == OP_STORE);
                                    ctl_next.mov     = (op6 == OP_MOV);
                                    ctl_next.sel_reg = addr_onehot;
                                end else begin
                                    ctl_next.illegal = 1'b1;
                                end
                            end
                            OP_COPY_X: begin
                                ctl_next.copy    = 1'b1;
                                ctl_next.sel_reg = NREG'(1);
                            end
                            OP_COPY_Y: begin
                                ctl_next.copy    = 1'b1;
                                ctl_next.sel_reg = NREG'(2);
                            end
                            OP_PUSH, OP_POP: begin
                                if (stk_ok) begin
                                    ctl_next.push  = (op6 == OP_PUSH);
                                    ctl_next.store = (op6 == OP_PUSH);
                                    ctl_next.pop   = (op6 == OP_POP);
                                    ctl_next.load  = (op6 == OP_POP);
                                    if (reg_ok) begin
                                        ctl_next.sel_reg = addr_onehot;
                                    end else if (REG_ADDR == ACC_ADDR) begin
                                        ctl_next.sel_acc = 1'b1;
                                    end else begin
                                        ctl_next.sel_pc = 1'b1;
                                    end
                                end else begin
                                    ctl_next.illegal = 1'b1;
                                end
                            end
                            OP_FACT: begin
                                if (reg_ok) begin
                                    ctl_next.ready    = 1'b0;
                                    ctl_next.alu      = 1'b1;
                                    ctl_next.sel_flag = 1'b1;
                                    ctl_next.mc_start = 1'b1;
                                    ctl_next.mc_busy  = 1'b1;
                                    wb_addr_next      = REG_ADDR;
                                    state_next        = S_WAIT;
`ifdef CU_TIMEOUT_EN
                                    wait_cnt_next = '0;
`endif
                                end else begin
                                    ctl_next.illegal = 1'b1;
                                end
                            end
                            default: ctl_next.illegal = 1'b1;
                        endcase
                    end
                end
            end
            S_WAIT: begin
                // The MC_START cycle is already a WAIT cycle, so MC_DONE there counts.
                if (MC_DONE) begin
                    ctl_next.sel_reg = wb_onehot;
                    state_next       = S_WB;
`ifdef CU_TIMEOUT_EN
                end else if (wait_cnt_reg == CW'(TIMEOUT_CYC - 1)) begin
                    ctl_next.ready   = 1'b1;
                    ctl_next.timeout = 1'b1;
                    ctl_next.illegal = 1'b1;
                    state_next       = S_IDLE;
                end else begin
                    ctl_next.mc_busy = 1'b1;
                    wait_cnt_next    = wait_cnt_reg + 1'b1;
`else
                end else begin
                    ctl_next.mc_busy = 1'b1;
`endif
                end
            end
            S_WB: begin
                ctl_next.ready = 1'b1;
                state_next     = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= S_IDLE;
            ctl_reg     <= '0;
            wb_addr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            ctl_reg     <= ctl_next;
            wb_addr_reg <= wb_addr_next;
        end
    end

    assign INSTR_READY = ctl_reg.ready;
    assign ALU         = ctl_reg.alu;
    assign SEL_FLAG    = ctl_reg.sel_flag;
    assign BRA         = ctl_reg.bra;
    assign COND_BRA    = ctl_reg.cond_bra;
    assign BR_COND     = ctl_reg.br_cond;
    assign LOAD        = ctl_reg.load;
    assign STORE       = ctl_reg.store;
    assign COPY        = ctl_reg.copy;
    assign PUSH        = ctl_reg.push;
    assign POP         = ctl_reg.pop;
    assign MOV         = ctl_reg.mov;
    assign SEL_REG     = ctl_reg.sel_reg;
    assign SEL_ACC     = ctl_reg.sel_acc;
    assign SEL_PC      = ctl_reg.sel_pc;
    assign MC_START    = ctl_reg.mc_start;
    assign MC_BUSY     = ctl_reg.mc_busy;
    assign ILLEGAL     = ctl_reg.illegal;
    assign TIMEOUT     = ctl_reg.timeout;

endmodule
